// File: rtl/mul3_accum_if.sv
// mul3_accum_if: beat input and frame-result output handshakes of the accumulator
interface mul3_accum_if #(
  parameter int ACC_W = 10,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/mul3_accum.sv
// mul3_accum: saturating frame accumulator of multiplier products with result handshake
module mul3_accum #(
  parameter int ACC_W = 10,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mul3_accum_if.slave  io
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, out_sum;
  logic [CNT_W-1:0] cnt, cnt_nx, out_cnt;
  logic             ovf, ovf_nx, out_ovf;
  logic [ACC_W:0]   sum;
  logic             take, done;
  assign io.in_ready  = state != OUT;
  assign io.out_valid = state == OUT;
  assign io.out_sum   = out_sum;
  assign io.out_cnt   = out_cnt;
  assign io.out_ovf   = out_ovf;
  assign take = io.in_valid && io.in_ready;
  assign done = io.out_valid && io.out_ready;
  // One extra bit of headroom exposes the carry that triggers saturation
  assign sum    = {1'b0, acc} + (ACC_W+1)'(io.in_prod);
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign cnt_nx = &cnt ? cnt : cnt + 1'b1;
  assign ovf_nx = ovf | sum[ACC_W] | (&cnt);
  always_comb begin
    state_nx = state;
    if (state == OUT) state_nx = io.out_ready ? IDLE : OUT;
    else if (take) state_nx = io.in_last ? OUT : ACCUM;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= ovf_nx;
        if (io.in_last) begin
          out_sum <= acc_nx;
          out_cnt <= cnt_nx;
          out_ovf <= ovf_nx;
        end
      end else if (done) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul3_accum.sv
// tb_mul3_accum: directed and randomized frames checked against an arithmetic frame model
module tb_mul3_accum;
  localparam int ACC_W = 10;
  localparam int CNT_W = 4;
  localparam int MAXS  = (1 << ACC_W) - 1;
  localparam int MAXC  = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int m_sum = 0;
  int m_n = 0;
  int e_sum = 0;
  int e_cnt = 0;
  int e_ovf = 0;
  always #5 clk = ~clk;
  mul3_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
  mul3_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_out(input string tag);
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(e_sum));
    check({tag, "_cnt"}, 32'(bus.out_cnt), 32'(e_cnt));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e_ovf));
  endtask
  // Drive one beat after an optional idle gap; on the last beat, form the expected result
  task automatic send(input int p, input bit l, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_prod  = 6'(p);
    bus.in_last  = l;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    m_sum += p;
    m_n++;
    if (l) begin
      e_sum = m_sum > MAXS ? MAXS : m_sum;
      e_cnt = m_n > MAXC ? MAXC : m_n;
      e_ovf = (m_sum > MAXS || m_n > MAXC) ? 1 : 0;
      m_sum = 0;
      m_n = 0;
      check("latency_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask
  task automatic drain(input string tag, input int stall);
    check_out(tag);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_prod   = 6'($urandom_range(0, 49));
      bus.in_last   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.out_sum), 32'(e_sum));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check({tag, "_held"}, 32'(bus.out_sum), 32'(e_sum));
  endtask
  task automatic frame(input string tag, input int n, input int p, input int stall);
    for (int i = 0; i < n; i++) send(p < 0 ? int'($urandom_range(0, 49)) : p, i == n - 1, 0);
    drain(tag, stall);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.out_sum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(7, 0, 0);
    send(12, 0, 0);
    send(49, 1, 0);
    check("f68_sum", 32'(bus.out_sum), 32'd68);
    check("f68_cnt", 32'(bus.out_cnt), 32'd3);
    check("f68_ovf", 32'(bus.out_ovf), 32'd0);
    drain("f68", 0);
    send(10, 0, 0);
    send(5, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sum", 32'(bus.out_sum), 32'd0);
    check("arst_cnt", 32'(bus.out_cnt), 32'd0);
    check("arst_ovf", 32'(bus.out_ovf), 32'd0);
    #1 rst_n = 1'b1;
    m_sum = 0;
    m_n = 0;
    @(posedge clk);
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    frame("after_rst", 1, 3, 0);
    frame("sum_sat", 21, 49, 0);
    check("sum_sat_abs", 32'(bus.out_sum), 32'(MAXS));
    frame("bp_a", 4, -1, 5);
    frame("bp_b", 3, -1, 0);
    frame("single", 1, 25, 0);
    check("single_abs", 32'(bus.out_sum), 32'd25);
    send(0, 0, 2);
    send(30, 0, 3);
    send(0, 1, 1);
    drain("zeros", 1);
    frame("cnt_sat", 16, 1, 0);
    check("cnt_sat_abs", 32'(bus.out_cnt), 32'd15);
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) send($urandom_range(0, 49), i == n - 1, $urandom_range(0, 2));
      drain("rand", $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
